timer_dev: RTL and testbench
============================

Name: timer_dev

Overview:
- Memory-mapped programmable down-counter timer on the CPU's external bridge bus.
- Occupies a 12-byte window (CTRL, PRESET, COUNT). The bridge decodes the base address (0x7F00 or 0x7F10) and presents word offset, write strobe and write data. The timer returns read data combinationally.
- Its interrupt line feeds one bit of the CPU's 6-bit hardware interrupt vector.
- Supports one-shot and periodic auto-reload modes.

Parameters:
PRESET_RST, 32'h0000_0000, reset value of PRESET register

Ports:
clk    input   1   system clock, all state updates on rising edge
reset  input   1   asynchronous, active-high; clears all state immediately
addr   input   2   word offset within window (byte addr[3:2]); 0=CTRL, 1=PRESET, 2=COUNT, 3=unmapped
we     input   1   write strobe, sampled at rising clk; already qualified by bridge decode
wd     input   32  write data
rd     output  32  read data, combinational from addr
irq    output  1   interrupt request = CTRL.IM & irq_flag

Behaviour:
- Register map:
  - CTRL[0] EN; CTRL[2:1] MODE (00 one-shot, 01 periodic, 1x treated as one-shot); CTRL[3] IM; CTRL[31:4] read 0, writes ignored.
  - PRESET: 32-bit read/write.
  - COUNT: 32-bit, read-only; writes ignored.
  - addr=3: reads 0, writes ignored.
- Reset (async): CTRL=0, PRESET=PRESET_RST, COUNT=0, state=IDLE, irq_flag=0. So rd reflects zeros (PRESET per param) and irq=0. Reset asserted mid-count aborts at once and no IRQ is generated.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 -> LOAD; else stay. COUNT holds.
  - LOAD: COUNT<=PRESET -> CNT. If EN=0 -> IDLE instead, with no load.
  - CNT: EN=0 -> IDLE, COUNT holds (pause; re-enable reloads). COUNT>1 -> COUNT-1, stay. COUNT<=1 -> COUNT<=0, state INT, irq_flag<=1.
  - INT, one-shot: hardware clears CTRL.EN -> IDLE. irq_flag stays 1.
  - INT, periodic: irq_flag<=0 -> LOAD. irq_flag is high exactly one cycle per period.
- Timing:
  - EN written at edge E0: LOAD after E1, COUNT=PRESET after E2.
  - For PRESET=N>=1, COUNT=0 and irq_flag=1 after edge E2+N.
  - PRESET=0: INT after E3 (edge E2+1); COUNT 0 is treated as expiry.
  - Periodic period = N+2 cycles between irq pulses.
- irq_flag clear (one-shot): any CPU write to CTRL or PRESET clears irq_flag at that edge.
- Simultaneous events:
  - CPU write to CTRL in the INT cycle wins over the hardware EN clear. Written EN/MODE/IM take effect, and irq_flag is cleared by the write.
  - A PRESET write while counting does not disturb COUNT; it is used at the next LOAD.
  - A CTRL write changing MODE while in CNT applies at the next INT.
- Decrement is unsigned 32-bit; no wrap below 0 is possible since COUNT<=1 triggers expiry.
- rd mux is purely combinational on addr and current register values; no read side effects.

Test Plan:
- Reset: assert reset mid-count with PRESET=5, EN=1 -> rd(CTRL)=0, rd(COUNT)=0, irq=0 within the same cycle, asynchronously.
- One-shot: PRESET=3, then write CTRL=0x9 (EN, IM, mode 0) at E0 -> COUNT reads 3,2,1,0 after E2..E5; irq=1 after E5; CTRL reads 0x8 after E6. Write PRESET=3 -> irq=0 next edge.
- Periodic: PRESET=2, CTRL=0xB -> irq one-cycle pulses 4 cycles apart (after E4, E8, E12). COUNT reloads to 2 after each pulse.
- Masked: PRESET=1, CTRL=0x1 -> irq stays 0. Internal expiry still occurs and CTRL reads 0x0 afterwards. Then write CTRL=0x8 -> irq remains 0, flag cleared.
- Pause/resume: PRESET=10, CTRL=0x1; after COUNT=6 write CTRL=0x0 -> COUNT holds 6 for 5 cycles. Write CTRL=0x1 -> COUNT reloads to 10.
- Edge cases: PRESET=0 one-shot with IM -> irq after E3. Write to COUNT (addr=2, wd=0x55) and to addr=3 -> no state change, rd(addr=3)=0. CPU writes CTRL=0x9 in the INT cycle -> EN stays 1, new count starts with irq=0.

Source files
------------

// File: rtl/timer_dev.sv
// Memory-mapped programmable down-counter timer with one-shot and periodic
// auto-reload modes; word registers CTRL, PRESET and COUNT, and a maskable interrupt.
module timer_dev #(
   parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        irq
);

   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        ctrl_en;
   logic [1:0]  ctrl_mode;
   logic        ctrl_im;
   logic [31:0] preset;
   logic [31:0] count;
   logic        irq_flag;

   logic        wr_ctrl;
   logic        wr_preset;
   logic        periodic;
   logic        do_load;
   logic        do_dec;
   logic        do_expire;
   logic        hw_clr_en;
   logic        hw_clr_flag;

   // Bus side: a write takes effect at the rising edge where we=1; there is no
   // wait state and reads have no side effects.
   assign wr_ctrl   = we && (addr == 2'd0);
   assign wr_preset = we && (addr == 2'd1);
   assign periodic  = (ctrl_mode == 2'b01);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      do_load     = 1'b0;
      do_dec      = 1'b0;
      do_expire   = 1'b0;
      hw_clr_en   = 1'b0;
      hw_clr_flag = 1'b0;
      case (state)
         IDLE: begin
            if (ctrl_en) state_nxt = LOAD;
         end
         LOAD: begin
            if (!ctrl_en) begin
               state_nxt = IDLE;
            end else begin
               do_load   = 1'b1;
               state_nxt = CNT;
            end
         end
         CNT: begin
            if (!ctrl_en) begin
               state_nxt = IDLE;
            end else if (count > 32'd1) begin
               do_dec = 1'b1;
            end else begin
               // A count of 0 (PRESET=0) expires just like 1.
               do_expire = 1'b1;
               state_nxt = INT;
            end
         end
         INT: begin
            if (periodic) begin
               hw_clr_flag = 1'b1;
               state_nxt   = LOAD;
            end else begin
               hw_clr_en = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_en   <= 1'b0;
         ctrl_mode <= 2'b00;
         ctrl_im   <= 1'b0;
         preset    <= PRESET_RST;
         count     <= 32'd0;
         irq_flag  <= 1'b0;
      end else begin
         // A CPU write to CTRL outranks the one-shot hardware EN clear.
         if (wr_ctrl) begin
            ctrl_en   <= wd[0];
            ctrl_mode <= wd[2:1];
            ctrl_im   <= wd[3];
         end else if (hw_clr_en) begin
            ctrl_en <= 1'b0;
         end

         if (wr_preset) preset <= wd;

         if (do_load)        count <= preset;
         else if (do_dec)    count <= count - 32'd1;
         else if (do_expire) count <= 32'd0;

         // Expiry wins over a same-edge clear so an interrupt is never lost.
         if (do_expire)                                   irq_flag <= 1'b1;
         else if (wr_ctrl || wr_preset || hw_clr_flag)    irq_flag <= 1'b0;
      end
   end

   always_comb begin
      rd = 32'd0;
      case (addr)
         2'd0:    rd = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
         2'd1:    rd = preset;
         2'd2:    rd = count;
         default: rd = 32'd0;
      endcase
   end

   assign irq = ctrl_im & irq_flag;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: one-shot, periodic, masked, pause/resume,
// PRESET=0, ignored writes, INT-cycle CTRL write and asynchronous reset.
module tb_timer_dev;

   localparam logic [31:0] P_RST = 32'hA5A5_0001;

   logic        clk;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        irq;

   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   timer_dev #(.PRESET_RST(P_RST)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wd    (wd),
      .rd    (rd),
      .irq   (irq)
   );

   // clock / reset
   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   // scoreboard compare: pops the oldest expectation
   task automatic compare(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
      addr = a;
      wd   = d;
      we   = 1'b1;
      @(posedge clk);
      #1;
      we   = 1'b0;
      wd   = 32'd0;
   endtask

   task automatic chk_rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      exp_q.push_back(exp);
      addr = a;
      #1;
      compare(tag, rd);
   endtask

   task automatic chk_irq(input logic exp, input string tag);
      exp_q.push_back({31'd0, exp});
      #1;
      compare(tag, {31'd0, irq});
   endtask

   initial begin
      reset = 1'b0;
      we    = 1'b0;
      addr  = 2'd0;
      wd    = 32'd0;
      #2 reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();

      // reset values
      chk_rd(2'd0, 32'd0, "rst_ctrl");
      chk_rd(2'd1, P_RST, "rst_preset");
      chk_rd(2'd2, 32'd0, "rst_count");
      chk_irq(1'b0, "rst_irq");

      // one-shot, PRESET=3
      cpu_write(2'd1, 32'd3);
      cpu_write(2'd0, 32'h9);            // E0
      step();                            // E1
      step();                            // E2
      chk_rd(2'd2, 32'd3, "os_cnt_e2");
      step();
      chk_rd(2'd2, 32'd2, "os_cnt_e3");
      step();
      chk_rd(2'd2, 32'd1, "os_cnt_e4");
      chk_irq(1'b0, "os_irq_e4");
      step();
      chk_rd(2'd2, 32'd0, "os_cnt_e5");
      chk_irq(1'b1, "os_irq_e5");
      chk_rd(2'd0, 32'h9, "os_ctrl_e5");
      step();
      chk_rd(2'd0, 32'h8, "os_ctrl_e6");
      chk_irq(1'b1, "os_irq_e6");
      cpu_write(2'd1, 32'd3);
      chk_irq(1'b0, "os_irq_clr");
      chk_rd(2'd2, 32'd0, "os_cnt_idle");

      // periodic, PRESET=2: pulses after E4, E8, E12
      cpu_write(2'd1, 32'd2);
      cpu_write(2'd0, 32'hB);            // E0
      for (int k = 1; k <= 12; k++) begin
         logic [31:0] ec;
         step();
         case (k % 4)
            2:       ec = 32'd2;
            3:       ec = 32'd1;
            default: ec = 32'd0;
         endcase
         chk_irq((k % 4) == 0, $sformatf("per_irq_%0d", k));
         chk_rd(2'd2, ec, $sformatf("per_cnt_%0d", k));
      end
      cpu_write(2'd0, 32'h0);
      step();
      chk_irq(1'b0, "per_stop_irq");
      chk_rd(2'd0, 32'h0, "per_stop_ctrl");

      // masked expiry
      cpu_write(2'd1, 32'd1);
      cpu_write(2'd0, 32'h1);            // E0
      for (int k = 1; k <= 5; k++) begin
         step();
         chk_irq(1'b0, $sformatf("mask_irq_%0d", k));
      end
      chk_rd(2'd0, 32'h0, "mask_ctrl");
      chk_rd(2'd2, 32'd0, "mask_cnt");
      cpu_write(2'd0, 32'h8);
      chk_irq(1'b0, "mask_im_irq");
      chk_rd(2'd0, 32'h8, "mask_im_ctrl");
      step();
      chk_irq(1'b0, "mask_im_irq2");

      // pause / resume, PRESET=10
      cpu_write(2'd1, 32'd10);
      cpu_write(2'd0, 32'h1);            // E0
      for (int k = 1; k <= 5; k++) step();
      chk_rd(2'd2, 32'd7, "pause_cnt_e5");
      cpu_write(2'd0, 32'h0);            // E6
      chk_rd(2'd2, 32'd6, "pause_cnt_e6");
      for (int k = 1; k <= 5; k++) begin
         step();
         chk_rd(2'd2, 32'd6, $sformatf("pause_hold_%0d", k));
      end
      cpu_write(2'd0, 32'h1);            // W
      step();
      chk_rd(2'd2, 32'd6, "resume_w1");
      step();
      chk_rd(2'd2, 32'd10, "resume_reload");
      step();
      chk_rd(2'd2, 32'd9, "resume_dec");
      cpu_write(2'd0, 32'h0);
      chk_rd(2'd2, 32'd8, "resume_stop");

      // PRESET=0 one-shot with IM
      cpu_write(2'd1, 32'd0);
      cpu_write(2'd0, 32'h9);            // E0
      step();
      step();                            // E2
      chk_irq(1'b0, "p0_irq_e2");
      chk_rd(2'd2, 32'd0, "p0_cnt_e2");
      step();                            // E3
      chk_irq(1'b1, "p0_irq_e3");
      cpu_write(2'd1, 32'd7);
      chk_irq(1'b0, "p0_irq_clr");

      // writes to COUNT and to the unmapped word are ignored
      cpu_write(2'd2, 32'h55);
      cpu_write(2'd3, 32'hFFFF_FFFF);
      chk_rd(2'd2, 32'd0, "ro_cnt");
      chk_rd(2'd3, 32'd0, "ro_addr3");
      chk_rd(2'd0, 32'h8, "ro_ctrl");
      chk_rd(2'd1, 32'd7, "ro_preset");

      // CTRL write in the INT cycle, PRESET=7
      cpu_write(2'd0, 32'h9);            // E0
      for (int k = 1; k <= 9; k++) step();
      chk_irq(1'b1, "intw_irq_e9");
      chk_rd(2'd2, 32'd0, "intw_cnt_e9");
      cpu_write(2'd0, 32'h9);            // E10, INT cycle
      chk_rd(2'd0, 32'h9, "intw_ctrl");
      chk_irq(1'b0, "intw_irq");
      step();
      step();
      chk_rd(2'd2, 32'd7, "intw_reload");
      chk_irq(1'b0, "intw_irq2");

      // PRESET write mid-count, then asynchronous reset mid-count
      cpu_write(2'd0, 32'h0);
      cpu_write(2'd1, 32'd5);
      cpu_write(2'd0, 32'h9);            // E0
      step();
      step();
      step();                            // E3
      chk_rd(2'd2, 32'd4, "rst_pre_cnt");
      cpu_write(2'd1, 32'd20);           // E4
      chk_rd(2'd2, 32'd3, "pw_cnt");
      chk_rd(2'd1, 32'd20, "pw_preset");
      #3 reset = 1'b1;
      chk_rd(2'd0, 32'd0, "arst_ctrl");
      chk_rd(2'd2, 32'd0, "arst_cnt");
      chk_rd(2'd1, P_RST, "arst_preset");
      chk_irq(1'b0, "arst_irq");
      step();
      step();
      reset = 1'b0;
      for (int k = 1; k <= 8; k++) step();
      chk_irq(1'b0, "post_rst_irq");
      chk_rd(2'd2, 32'd0, "post_rst_cnt");
      chk_rd(2'd0, 32'd0, "post_rst_ctrl");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
